// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: response owner, FSM state, word func3.
// Pure declarations: no latency; no backpressure.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D,
    OWN_DBG
  } owner_t;

  typedef enum logic {
    ARB,
    DBG_LOCK
  } arb_state_t;

  localparam logic [2:0] FUNC3_WORD = 3'b010;

  // Bit positions in the request/grant vectors.
  localparam int REQ_IF  = 0;
  localparam int REQ_D   = 1;
  localparam int REQ_DBG = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle of the memory-port arbiter (slave = arbiter side).
// Grants are same-cycle; a requester holds req until granted, and read data returns one cycle later.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_func3;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              dbg_req;
  logic              dbg_wen;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [2:0]        dbg_func3;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_lock;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_func3;
  logic [DATA_W-1:0] mem_rd;

  modport master (
    output if_req, if_addr,
    output d_req, d_wen, d_addr, d_wdata, d_func3,
    output dbg_req, dbg_wen, dbg_addr, dbg_wdata, dbg_func3, dbg_lock,
    output mem_rd,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_wen, mem_wdata, mem_func3
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_wen, d_addr, d_wdata, d_func3,
    input  dbg_req, dbg_wen, dbg_addr, dbg_wdata, dbg_func3, dbg_lock,
    input  mem_rd,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_wen, mem_wdata, mem_func3
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational one-hot grant picker: dbg > d > if, fetch promoted over d when starved, lock admits dbg only.
// Zero latency; losers simply see no grant and keep requesting.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  arb_state_t state,
  input  logic       starve,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    if (req[REQ_DBG]) begin
      gnt[REQ_DBG] = 1'b1;
    end else if (state == ARB) begin
      if (req[REQ_IF] && (starve || !req[REQ_D])) begin
        gnt[REQ_IF] = 1'b1;
      end else if (req[REQ_D]) begin
        gnt[REQ_D] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// One-access-per-cycle arbiter for the shared memory port (fetch, load/store, debug); grant same cycle, read data +1 cycle.
// Losing requesters hold req until granted; MEM_ARB_STATS_EN adds wrapping grant/conflict counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]        stat_if_grants,
  output logic [15:0]        stat_d_grants,
  output logic [15:0]        stat_dbg_grants,
  output logic [15:0]        stat_conflicts
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t        state;
  arb_state_t        eff_state;
  arb_state_t        state_nxt;
  logic [3:0]        starve_cnt;
  owner_t            resp_owner;
  owner_t            owner_nxt;
  logic [ADDR_W-1:0] addr_q;

  logic [2:0]        req;
  logic [2:0]        gnt;
  logic              starve;

  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_wen_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [2:0]        mem_func3_c;

  // Requests are masked during reset so grants fall immediately with rst.
  assign req = rst ? 3'b000 : {bus.dbg_req, bus.d_req, bus.if_req};

  // Dropping dbg_lock releases the lock for this cycle's arbitration too.
  assign eff_state = ((state == DBG_LOCK) && bus.dbg_lock) ? DBG_LOCK : ARB;
  assign starve    = (starve_cnt == LIMIT);

  mem_arb_pick u_pick (
    .req    (req),
    .state  (eff_state),
    .starve (starve),
    .gnt    (gnt)
  );

  assign bus.if_gnt  = gnt[REQ_IF];
  assign bus.d_gnt   = gnt[REQ_D];
  assign bus.dbg_gnt = gnt[REQ_DBG];

  always_comb begin
    mem_addr_c  = addr_q;
    mem_wen_c   = 1'b0;
    mem_wdata_c = '0;
    mem_func3_c = FUNC3_WORD;
    owner_nxt   = OWN_NONE;
    if (gnt[REQ_DBG]) begin
      mem_addr_c  = bus.dbg_addr;
      mem_wen_c   = bus.dbg_wen;
      mem_wdata_c = bus.dbg_wdata;
      mem_func3_c = bus.dbg_func3;
      owner_nxt   = bus.dbg_wen ? OWN_NONE : OWN_DBG;
    end else if (gnt[REQ_D]) begin
      mem_addr_c  = bus.d_addr;
      mem_wen_c   = bus.d_wen;
      mem_wdata_c = bus.d_wdata;
      mem_func3_c = bus.d_func3;
      owner_nxt   = bus.d_wen ? OWN_NONE : OWN_D;
    end else if (gnt[REQ_IF]) begin
      mem_addr_c  = bus.if_addr;
      owner_nxt   = OWN_IF;
    end
  end

  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wen   = mem_wen_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_func3 = mem_func3_c;

  assign state_nxt = (bus.dbg_lock && ((eff_state == DBG_LOCK) || gnt[REQ_DBG])) ? DBG_LOCK : ARB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      starve_cnt <= 4'd0;
      resp_owner <= OWN_NONE;
      addr_q     <= '0;
    end else begin
      state      <= state_nxt;
      resp_owner <= owner_nxt;
      if (|gnt) begin
        addr_q <= mem_addr_c;
      end
      // Starvation count is frozen while debug holds the lock.
      if (eff_state == ARB) begin
        if (!bus.if_req || gnt[REQ_IF]) begin
          starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

  assign bus.if_rvalid  = (resp_owner == OWN_IF);
  assign bus.d_rvalid   = (resp_owner == OWN_D);
  assign bus.dbg_rvalid = (resp_owner == OWN_DBG);
  assign bus.if_rdata   = (resp_owner == OWN_IF)  ? bus.mem_rd : '0;
  assign bus.d_rdata    = (resp_owner == OWN_D)   ? bus.mem_rd : '0;
  assign bus.dbg_rdata  = (resp_owner == OWN_DBG) ? bus.mem_rd : '0;

`ifdef MEM_ARB_STATS_EN
  logic conflict;
  assign conflict = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_if_grants  <= 16'd0;
      stat_d_grants   <= 16'd0;
      stat_dbg_grants <= 16'd0;
      stat_conflicts  <= 16'd0;
    end else begin
      if (gnt[REQ_IF])  stat_if_grants  <= stat_if_grants + 16'd1;
      if (gnt[REQ_D])   stat_d_grants   <= stat_d_grants + 16'd1;
      if (gnt[REQ_DBG]) stat_dbg_grants <= stat_dbg_grants + 16'd1;
      if (conflict)     stat_conflicts  <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, a queue-free behavioural model checked every cycle,
// and literal expectations for the headline scenarios (define MEM_ARB_STATS_EN to cover the counters).
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_if_grants, stat_d_grants, stat_dbg_grants, stat_conflicts;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_if_grants  (stat_if_grants),
    .stat_d_grants   (stat_d_grants),
    .stat_dbg_grants (stat_dbg_grants),
    .stat_conflicts  (stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents before any store.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  // Synchronous-read memory behind the port.
  logic [31:0] tbmem [logic [31:0]];
  always @(posedge clk) begin
    bus.mem_rd <= tbmem.exists(bus.mem_addr) ? tbmem[bus.mem_addr] : dflt(bus.mem_addr);
    if (bus.mem_wen) tbmem[bus.mem_addr] = bus.mem_wdata;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: who is owed read data, what it must be, lock and starvation bookkeeping.
  int          m_cnt;
  bit          m_lock;
  int          p_own;      // 0 none, 1 fetch, 2 data, 3 debug
  logic [31:0] p_dat;
  logic [31:0] m_last;
  logic [31:0] sh [logic [31:0]];

  task automatic model_check();
    int          w;
    bit          lk;
    logic [31:0] ea, ewd;
    logic        ewen;
    logic [2:0]  ef3;
    logic [2:0]  eg;
    if (rst) begin
      m_cnt = 0; m_lock = 0; p_own = 0; m_last = 32'h0;
      return;
    end
    chk1("if_rvalid",  bus.if_rvalid,  p_own == 1);
    chk1("d_rvalid",   bus.d_rvalid,   p_own == 2);
    chk1("dbg_rvalid", bus.dbg_rvalid, p_own == 3);
    if (p_own == 1) chk("if_rdata",  bus.if_rdata,  p_dat);
    if (p_own == 2) chk("d_rdata",   bus.d_rdata,   p_dat);
    if (p_own == 3) chk("dbg_rdata", bus.dbg_rdata, p_dat);
    if (p_own == 0) chk("idle_rdata", bus.if_rdata | bus.d_rdata | bus.dbg_rdata, 32'h0);

    lk = m_lock && bus.dbg_lock;
    if (bus.dbg_req) w = 3;
    else if (lk) w = 0;
    else if (bus.d_req && !(bus.if_req && m_cnt == LIMIT)) w = 2;
    else if (bus.if_req) w = 1;
    else w = 0;

    eg = 3'b000;
    if (w != 0) eg[w-1] = 1'b1;
    chk("gnt_vec", {29'h0, bus.dbg_gnt, bus.d_gnt, bus.if_gnt}, {29'h0, eg});

    ewd = 32'h0;
    case (w)
      1:       begin ea = bus.if_addr;  ewen = 1'b0;        ef3 = 3'b010; end
      2:       begin ea = bus.d_addr;   ewen = bus.d_wen;   ef3 = bus.d_func3;   ewd = bus.d_wdata; end
      3:       begin ea = bus.dbg_addr; ewen = bus.dbg_wen; ef3 = bus.dbg_func3; ewd = bus.dbg_wdata; end
      default: begin ea = m_last;       ewen = 1'b0;        ef3 = 3'b010; end
    endcase
    chk("mem_addr", bus.mem_addr, ea);
    chk1("mem_wen", bus.mem_wen, ewen);
    chk("mem_func3", {29'h0, bus.mem_func3}, {29'h0, ef3});
    if (ewen) chk("mem_wdata", bus.mem_wdata, ewd);

    m_last = ea;
    p_own  = (w != 0 && !ewen) ? w : 0;
    p_dat  = sh.exists(ea) ? sh[ea] : dflt(ea);
    if (w != 0 && ewen) sh[ea] = ewd;
    if (!lk) m_cnt = (w == 1 || !bus.if_req) ? 0 : ((m_cnt < LIMIT) ? m_cnt + 1 : m_cnt);
    m_lock = bus.dbg_lock && (lk || w == 3);
  endtask

  // One cycle: model checks at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic r, input logic [31:0] a);
    bus.if_req = r; bus.if_addr = a;
  endtask

  task automatic set_d(input logic r, input logic wen, input logic [31:0] a, input logic [31:0] wd);
    bus.d_req = r; bus.d_wen = wen; bus.d_addr = a; bus.d_wdata = wd; bus.d_func3 = 3'b010;
  endtask

  task automatic set_dbg(input logic r, input logic wen, input logic [31:0] a, input logic [31:0] wd,
                         input logic lock);
    bus.dbg_req = r; bus.dbg_wen = wen; bus.dbg_addr = a; bus.dbg_wdata = wd;
    bus.dbg_func3 = 3'b010; bus.dbg_lock = lock;
  endtask

  task automatic idle();
    set_if(0, 32'h0);
    set_d(0, 0, 32'h0, 32'h0);
    set_dbg(0, 0, 32'h0, 32'h0, 0);
  endtask

  logic [2:0] seq_g [10];

  initial begin
    rst = 1'b1;
    m_cnt = 0; m_lock = 0; p_own = 0; p_dat = 32'h0; m_last = 32'h0;
    idle();
    #2;
    chk("rst_gnt", {29'h0, bus.dbg_gnt, bus.d_gnt, bus.if_gnt}, 32'h0);
    chk("rst_rvalid", {29'h0, bus.dbg_rvalid, bus.d_rvalid, bus.if_rvalid}, 32'h0);
    chk1("rst_mem_wen", bus.mem_wen, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_func3", {29'h0, bus.mem_func3}, 32'h2);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_rdata", bus.if_rdata | bus.d_rdata | bus.dbg_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Single fetch.
    set_if(1, 32'h40);
    #1 chk1("fetch_gnt", bus.if_gnt, 1'b1);
    chk("fetch_addr", bus.mem_addr, 32'h40);
    tick();
    set_if(0, 32'h0);
    #1 chk1("fetch_rvalid_c1", bus.if_rvalid, 1'b1);
    chk("fetch_rdata_c1", bus.if_rdata, 32'h0050_0093);
    tick();
    #1 chk1("fetch_rvalid_c2", bus.if_rvalid, 1'b0);
    tick();

    // Fetch vs continuous loads: fetch promoted after LIMIT denials.
    set_if(1, 32'h44);
    set_d(1, 0, 32'h100, 32'h0);
    for (int k = 0; k < 10; k++) begin
      #1 seq_g[k] = {bus.dbg_gnt, bus.d_gnt, bus.if_gnt};
      if (k == 5) chk("starve_after_fetch", {28'h0, dut.starve_cnt}, 32'h0);
      tick();
    end
    for (int k = 0; k < 10; k++)
      chk($sformatf("starve_seq_%0d", k), {29'h0, seq_g[k]}, (k == 4 || k == 9) ? 32'h1 : 32'h2);
    idle();
    tick();

    // Store then load to the same address.
    set_d(1, 1, 32'h200, 32'hDEAD_BEEF);
    #1 chk1("store_wen", bus.mem_wen, 1'b1);
    chk1("store_gnt", bus.d_gnt, 1'b1);
    tick();
    set_d(1, 0, 32'h200, 32'h0);
    #1 chk1("load_wen", bus.mem_wen, 1'b0);
    chk1("store_no_rvalid", bus.d_rvalid, 1'b0);
    tick();
    set_d(0, 0, 32'h0, 32'h0);
    #1 chk1("load_rvalid", bus.d_rvalid, 1'b1);
    chk("load_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    tick();

    // Debug lock keeps fetch out until dbg_lock falls.
    set_if(1, 32'h80);
    for (int k = 0; k < 3; k++) begin
      set_dbg(1, 1, 32'h300 + 32'(k * 4), 32'(k + 7), 1);
      #1 chk1("lock_if_gnt", bus.if_gnt, 1'b0);
      chk1("lock_dbg_gnt", bus.dbg_gnt, 1'b1);
      tick();
    end
    set_dbg(0, 0, 32'h0, 32'h0, 1);
    #1 chk1("lock_hold_if_gnt", bus.if_gnt, 1'b0);
    tick();
    set_dbg(0, 0, 32'h0, 32'h0, 0);
    #1 chk1("unlock_if_gnt", bus.if_gnt, 1'b1);
    tick();
    idle();
    tick();

    // Mixed request patterns, including debug/data reads of earlier stores.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] p;
      p = 4'(i);
      set_if(p[0], 32'h400 + 32'(i * 4));
      set_d(p[1], p[3], (i % 3 == 0) ? 32'h304 : 32'h500 + 32'(i * 4), 32'h1000 + 32'(i));
      set_dbg(p[2], 0, 32'h200, 32'h0, 0);
      tick();
    end
    idle();
    tick();

    // Asynchronous reset in the middle of a debug read.
    set_if(1, 32'h40);
    set_d(1, 0, 32'h100, 32'h0);
    set_dbg(1, 0, 32'h308, 32'h0, 0);
    #1 chk1("pre_rst_dbg_gnt", bus.dbg_gnt, 1'b1);
    tick();
    chk1("pre_rst_rvalid", bus.dbg_rvalid, 1'b1);
    #1 rst = 1'b1;
    #1 chk("mid_rst_gnt", {29'h0, bus.dbg_gnt, bus.d_gnt, bus.if_gnt}, 32'h0);
    chk("mid_rst_rvalid", {29'h0, bus.dbg_rvalid, bus.d_rvalid, bus.if_rvalid}, 32'h0);
    tick();
    rst = 1'b0;
    #1 chk("post_rst_gnt", {29'h0, bus.dbg_gnt, bus.d_gnt, bus.if_gnt}, 32'h4);
    tick();
    idle();
    tick();

`ifdef MEM_ARB_STATS_EN
    begin
      logic [15:0] c0, g0;
      c0 = stat_conflicts;
      g0 = stat_if_grants + stat_d_grants + stat_dbg_grants;
      set_if(1, 32'h40);
      set_d(1, 0, 32'h100, 32'h0);
      for (int k = 0; k < 5; k++) tick();
      idle();
      tick();
      chk("stat_conflicts", 32'(stat_conflicts - c0), 32'd5);
      chk("stat_grants", 32'(16'(stat_if_grants + stat_d_grants + stat_dbg_grants) - g0), 32'd5);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
